melody_sequencer: RTL and testbench

- Upstream stage of the piano message display: plays a stored demo melody note-by-note and drives the display FSM's `val` input (the `playing` output) for the whole song.
- Outputs a note code to the tone generator.
- Aborts when KEY2 is pressed or any piano switch goes high, so the display FSM and this block always agree on stop/start.

---
 rtl/melody_pkg.sv | 48 ++++
 rtl/melody_sequencer_rom.sv | 27 ++
 rtl/melody_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// ---------------------------------------------------------------------------
// melody_pkg
// Shared types and constants for the demo-melody sequencer.
//   state_t      : sequencer FSM states
//   NOTE_*       : 3-bit note codes sent to the tone generator (0 = rest)
//   rom_entry_t  : one melody ROM word {note[2:0], beats[2:0]}
//   SONG         : the 16-entry demo song
//   eff_beats()  : duration field with 0 promoted to 1 beat
// ---------------------------------------------------------------------------
package melody_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    NOTE = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  typedef struct packed {
    logic [2:0] note;
    logic [2:0] beats;
  } rom_entry_t;

  // E1 D1 C1 D1 E1 E1 E2 D1 D1 D2 E1 G1 G2 R1 E1 C2
  localparam rom_entry_t SONG [16] = '{
    '{NOTE_E,    3'd1}, '{NOTE_D, 3'd1}, '{NOTE_C, 3'd1}, '{NOTE_D, 3'd1},
    '{NOTE_E,    3'd1}, '{NOTE_E, 3'd1}, '{NOTE_E, 3'd2}, '{NOTE_D, 3'd1},
    '{NOTE_D,    3'd1}, '{NOTE_D, 3'd2}, '{NOTE_E, 3'd1}, '{NOTE_G, 3'd1},
    '{NOTE_G,    3'd2}, '{NOTE_REST, 3'd1}, '{NOTE_E, 3'd1}, '{NOTE_C, 3'd2}
  };

  // A zero-length note would make the duration counter underflow, so a
  // beats field of 0 plays as a single beat.
  function automatic logic [2:0] eff_beats(input logic [2:0] beats);
    return (beats == 3'd0) ? 3'd1 : beats;
  endfunction

endpackage

// File: rtl/melody_sequencer_rom.sv
// ---------------------------------------------------------------------------
// melody_sequencer_rom
// Synchronous 16x6 read-only store of the demo song, one cycle of latency.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-low reset (clears the output word)
//   addr  : entry index to read
//   data  : registered ROM word {note, beats}
// ---------------------------------------------------------------------------
module melody_sequencer_rom
  import melody_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addr,
  output rom_entry_t data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else begin
      data <= SONG[addr];
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
// Plays the stored demo melody note by note and holds `playing` high for the
// whole song so the downstream display FSM tracks start/stop with us.
// Any stop request (KEY2) or manual piano switch aborts back to IDLE.
//
// Build option: define MELODY_LOOP_EN to repeat the song until aborted
// (song_done then pulses at every wrap and DONE is never entered).
//
// Parameters:
//   BEAT_CYCLES : clock cycles per beat
//   GAP_CYCLES  : silent cycles between notes (0 behaves as 1)
//   SONG_LEN    : number of ROM entries played, 1..16
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   start_n     : play pushbutton, active-low, asynchronous to clk
//   stop_n      : KEY2, active-low, already debounced and synchronous
//   piano_keys  : manual-play switches 17..11, any bit high aborts
//   playing     : high in LOAD/NOTE/GAP
//   note        : note code, non-zero only in NOTE
//   note_valid  : high in NOTE
//   note_idx    : index of the current ROM entry
//   song_done   : one-cycle pulse on normal completion
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a start press with no stop and no keys
// LOAD  | ROM word for idx is available; load the note duration
// NOTE  | note sounding; duration counter counts down to 0
// GAP   | silence between notes; gap counter counts down to 0
// DONE  | song finished; song_done pulses for this one cycle
// ---------------------------------------------------------------------------
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000,
  parameter int SONG_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       stop_n,
  input  logic [6:0] piano_keys,
  output logic       playing,
  output logic [2:0] note,
  output logic       note_valid,
  output logic [3:0] note_idx,
  output logic       song_done
);

  localparam int               CNT_W    = $clog2(7 * BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(SONG_LEN - 1);

  state_t           state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dur_load;
  logic [3:0]       rom_addr;
  rom_entry_t       rom_q;

  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             start_evt;
  logic             abort;

  // Start button: two-flop synchronizer, a history flop for the falling
  // edge, and a registered event so the FSM only sees a clean 1-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      hist      <= 1'b1;
      start_evt <= 1'b0;
    end else begin
      sync1     <= start_n;
      sync2     <= sync1;
      hist      <= sync2;
      start_evt <= ~sync2 & hist;
    end
  end

  assign abort = ~stop_n | (piano_keys != 7'd0);

  // The ROM address anticipates the index the FSM is about to load, so the
  // word for the new entry is already registered when LOAD is entered.
  always_comb begin
    rom_addr = idx;
    if (state == IDLE) begin
      rom_addr = 4'd0;
    end else if (state == GAP && cnt == '0) begin
      rom_addr = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    end
  end

  melody_sequencer_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr),
    .data (rom_q)
  );

  always_comb begin
    dur_load = CNT_W'(eff_beats(rom_q.beats)) * CNT_W'(BEAT_CYCLES) - CNT_ONE;
  end

  assign note_idx = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= '0;
      playing    <= 1'b0;
      note       <= NOTE_REST;
      note_valid <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        idx        <= 4'd0;
        cnt        <= '0;
        playing    <= 1'b0;
        note       <= NOTE_REST;
        note_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_evt && stop_n && piano_keys == 7'd0) begin
              state   <= LOAD;
              idx     <= 4'd0;
              playing <= 1'b1;
            end
          end
          LOAD: begin
            cnt        <= dur_load;
            note       <= rom_q.note;
            note_valid <= 1'b1;
            state      <= NOTE;
          end
          NOTE: begin
            if (cnt == '0) begin
              cnt        <= GAP_LOAD;
              note       <= NOTE_REST;
              note_valid <= 1'b0;
              state      <= GAP;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              if (idx == LAST_IDX) begin
                song_done <= 1'b1;
`ifdef MELODY_LOOP_EN
                idx   <= 4'd0;
                state <= LOAD;
`else
                playing <= 1'b0;
                state   <= DONE;
`endif
              end else begin
                idx   <= idx + 4'd1;
                state <= LOAD;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
// Directed bench for melody_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2,
// SONG_LEN=3 (song head E1 D1 C1 -> note codes 3, 2, 1).
// Observed vector: {playing, note_valid, note[2:0], note_idx[3:0], song_done}.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_n = 1'b1;
  logic       stop_n = 1'b1;
  logic [6:0] piano_keys = 7'd0;
  logic       playing;
  logic [2:0] note;
  logic       note_valid;
  logic [3:0] note_idx;
  logic       song_done;
  logic [9:0] obs;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .BEAT_CYCLES (4),
    .GAP_CYCLES  (2),
    .SONG_LEN    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_n    (start_n),
    .stop_n     (stop_n),
    .piano_keys (piano_keys),
    .playing    (playing),
    .note       (note),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .song_done  (song_done)
  );

  assign obs = {playing, note_valid, note, note_idx, song_done};

  // Expected vector t cycles after entering the first LOAD.
  // Each entry: LOAD 1 cycle, NOTE 4 cycles, GAP 2 cycles = 7 cycles.
  function automatic logic [9:0] exp_vec(input int t);
    int         n;
    int         ph;
    logic       v;
    logic       sd;
    logic [2:0] nt;
`ifdef MELODY_LOOP_EN
    n  = (t / 7) % 3;
    sd = (t > 0) && (t % 21 == 0);
`else
    if (t == 21) return {1'b0, 1'b0, 3'd0, 4'd2, 1'b1};
    if (t > 21)  return {1'b0, 1'b0, 3'd0, 4'd2, 1'b0};
    n  = t / 7;
    sd = 1'b0;
`endif
    ph = t % 7;
    v  = (ph >= 1) && (ph <= 4);
    nt = !v ? 3'd0 : (n == 0) ? 3'd3 : (n == 1) ? 3'd2 : 3'd1;
    return {1'b1, v, nt, 4'(n), sd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start_n low and return at the first cycle of LOAD (edge k+3).
  task automatic launch();
    repeat (3) tick();
    start_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic stop_pulse();
    stop_n = 1'b0;
    tick();
    stop_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL reset_held: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
    rst = 1'b1;
    repeat (2) begin
      tick();
      total_cnt++;
      if (obs !== 10'd0) $display("FAIL reset_released: got %b expected %b", obs, 10'd0);
      else pass_cnt++;
    end
  endtask

  task automatic test_play();
    int sd_cnt;
    sd_cnt = 0;
    repeat (3) tick();
    start_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (playing !== 1'b0) $display("FAIL start_latency edge %0d: got %b expected 0", i, playing);
      else pass_cnt++;
    end
    tick();
    for (int t = 0; t < 24; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL play t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (song_done) sd_cnt++;
      tick();
    end
    total_cnt++;
    if (sd_cnt !== 1) $display("FAIL play_done_count: got %0d expected 1", sd_cnt);
    else pass_cnt++;
`ifdef MELODY_LOOP_EN
    stop_pulse();
`endif
  endtask

  task automatic test_stop();
    launch();
    for (int t = 0; t < 10; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL stop_pre t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (t < 9) tick();
    end
    stop_pulse();
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (obs !== 10'd0) $display("FAIL stop_abort c=%0d: got %b expected %b", i, obs, 10'd0);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_keys();
    launch();
    for (int t = 0; t < 6; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL keys_pre t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (t < 5) tick();
    end
    piano_keys = 7'b0000100;
    tick();
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL keys_abort: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
    start_n = 1'b0;
    repeat (2) tick();
    start_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (obs !== 10'd0) $display("FAIL keys_start_blocked c=%0d: got %b expected %b", i, obs, 10'd0);
      else pass_cnt++;
    end
    piano_keys = 7'd0;
    repeat (4) tick();
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL keys_release_idle: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sd_cnt;
    sd_cnt = 0;
    launch();
    for (int t = 0; t < 24; t++) begin
      if (t == 1) start_n = 1'b1;
      if (t == 3) start_n = 1'b0;
      if (t == 6) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL restart_ignored t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (song_done) sd_cnt++;
      tick();
    end
    total_cnt++;
    if (sd_cnt !== 1) $display("FAIL restart_done_count: got %0d expected 1", sd_cnt);
    else pass_cnt++;
`ifdef MELODY_LOOP_EN
    stop_pulse();
`endif
  endtask

`ifdef MELODY_LOOP_EN
  task automatic test_loop();
    int sd_cnt;
    sd_cnt = 0;
    launch();
    for (int t = 0; t < 45; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL loop t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (song_done) sd_cnt++;
      tick();
    end
    total_cnt++;
    if (sd_cnt !== 2) $display("FAIL loop_done_count: got %0d expected 2", sd_cnt);
    else pass_cnt++;
    stop_pulse();
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL loop_stop: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
  endtask
`endif

  task automatic test_async_reset();
    launch();
    for (int t = 0; t < 3; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL areset_pre t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      if (t < 2) tick();
    end
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL areset_immediate: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (obs !== 10'd0) $display("FAIL areset_after: got %b expected %b", obs, 10'd0);
    else pass_cnt++;
    launch();
    for (int t = 0; t < 9; t++) begin
      if (t == 1) start_n = 1'b1;
      total_cnt++;
      if (obs !== exp_vec(t)) $display("FAIL areset_replay t=%0d: got %b expected %b", t, obs, exp_vec(t));
      else pass_cnt++;
      tick();
    end
    stop_pulse();
  endtask

  initial begin
    test_reset();
    test_play();
    test_stop();
    test_keys();
    test_back_to_back();
`ifdef MELODY_LOOP_EN
    test_loop();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
